// File: rtl/count_bcd_display_if.sv
// rtl/count_bcd_display_if.sv - count input and BCD/display outputs of count_bcd_display
interface count_bcd_display_if;
  logic [7:0]  q;
  logic [11:0] bcd;
  logic        bcd_valid;
  logic        busy;
  logic [3:0]  an;
  logic [6:0]  seg;

  modport master (
    output q,
    input  bcd, bcd_valid, busy, an, seg
  );

  modport slave (
    input  q,
    output bcd, bcd_valid, busy, an, seg
  );
endinterface

// File: rtl/count_bcd_display.sv
// rtl/count_bcd_display.sv - sync/filter a ripple count, convert to BCD, scan a 7-segment display
module count_bcd_display #(
  parameter int SCAN_DIV = 16
) (
  input  logic            clk,
  input  logic            reset,
  count_bcd_display_if.slave bus
);

  localparam int SCAN_W = $clog2(SCAN_DIV);

  typedef enum logic {IDLE, SHIFT} state_t;

  // Input conditioning: q is asynchronous and ripples, so it is only trusted
  // once two consecutive synchronised samples agree.
  logic [7:0] s1, s2, s3;
  logic       stable;

  state_t      state_q, state_d;
  logic [19:0] shift_q, shift_d;
  logic [2:0]  iter_q, iter_d;
  logic [7:0]  last_q, last_d;
  logic [11:0] bcd_q, bcd_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;

  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [1:0]        sel_q, sel_d;
  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;

  logic [19:0] adjusted;
  logic [19:0] shifted;
  logic [3:0]  digit;
  logic        blank;

  assign stable = (s2 == s3);

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Conversion FSM next-state: one add-3-then-shift step per SHIFT cycle.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    iter_d   = iter_q;
    last_d   = last_q;
    bcd_d    = bcd_q;
    valid_d  = 1'b0;
    busy_d   = busy_q;
    adjusted = {add3(shift_q[19:16]), add3(shift_q[15:12]), add3(shift_q[11:8]), shift_q[7:0]};
    shifted  = adjusted << 1;
    case (state_q)
      IDLE: begin
        if (stable && (s3 != last_q)) begin
          shift_d = {12'b0, s3};
          last_d  = s3;
          iter_d  = 3'd0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_d = shifted;
        iter_d  = iter_q + 3'd1;
        if (iter_q == 3'd7) begin
          bcd_d   = shifted[19:8];
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Display scan next-state: an/seg are registered from the current select and bcd.
  always_comb begin
    scan_d = scan_q;
    sel_d  = sel_q;
    an_d   = 4'b1111;
    digit  = 4'd0;
    blank  = 1'b0;
    if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_d = '0;
      sel_d  = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
    end else begin
      scan_d = scan_q + SCAN_W'(1);
    end
    case (sel_q)
      2'd0: begin
        an_d  = 4'b1110;
        digit = bcd_q[3:0];
      end
      2'd1: begin
        an_d  = 4'b1101;
        digit = bcd_q[7:4];
        blank = (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
      end
      2'd2: begin
        an_d  = 4'b1011;
        digit = bcd_q[11:8];
        blank = (bcd_q[11:8] == 4'd0);
      end
      default: begin
        an_d  = 4'b1111;
        blank = 1'b1;
      end
    endcase
    seg_d = blank ? 7'b1111111 : seg_code(digit);
  end

  // State register for synchroniser, converter and display scan.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1      <= 8'd0;
      s2      <= 8'd0;
      s3      <= 8'd0;
      state_q <= IDLE;
      shift_q <= 20'd0;
      iter_q  <= 3'd0;
      last_q  <= 8'd0;
      bcd_q   <= 12'h000;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      scan_q  <= '0;
      sel_q   <= 2'd0;
      an_q    <= 4'b1110;
      seg_q   <= 7'b1000000;
    end else begin
      s1      <= bus.q;
      s2      <= s1;
      s3      <= s2;
      state_q <= state_d;
      shift_q <= shift_d;
      iter_q  <= iter_d;
      last_q  <= last_d;
      bcd_q   <= bcd_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      scan_q  <= scan_d;
      sel_q   <= sel_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign bus.bcd       = bcd_q;
  assign bus.bcd_valid = valid_q;
  assign bus.busy      = busy_q;
  assign bus.an        = an_q;
  assign bus.seg       = seg_q;

endmodule
